act_stage: RTL

Downstream neighbour of `dot_prod`: captures the NROW-wide result vector when `dot_prod` raises `dataReady`, adds a per-row bias, saturates, applies a piecewise-linear activation, and streams the NROW results out one row per cycle over a valid/ready handshake. It sits between the matrix-vector stage and the next layer's input buffer. It frees `dot_prod` to start the next sample while the current vector is still being drained.

---
 rtl/act_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/act_stage.sv
// act_stage: captures a dot_prod result vector, adds per-row bias with saturation,
// applies hard sigmoid (or hard tanh when ACT_TANH_EN is defined) and streams one row per cycle.
module act_stage #(
    parameter int NROW         = 16,
    parameter int QN           = 6,
    parameter int QM           = 11,
    parameter int BITWIDTH     = QN + QM + 1,
    parameter int IDX_BITWIDTH = $clog2(NROW)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     dataReady,
    input  logic [NROW*BITWIDTH-1:0] outputVec,
    input  logic [NROW*BITWIDTH-1:0] biasVec,
    input  logic                     outReady,
    output logic                     outValid,
    output logic [BITWIDTH-1:0]      outData,
    output logic [IDX_BITWIDTH-1:0]  outIndex,
    output logic                     outLast,
    output logic                     busy,
    output logic                     overrun,
    output logic                     stateDbg
);

    // Handshake: a beat transfers on a rising edge where outValid && outReady; once outValid
    // is high the payload holds until that transfer and outValid only drops after it (or on reset).

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic signed [BITWIDTH-1:0] MAXV    = {1'b0, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [BITWIDTH-1:0] MINV    = {1'b1, {(BITWIDTH-1){1'b0}}};
    localparam logic signed [BITWIDTH-1:0] ONE     = BITWIDTH'(2**QM);
    localparam logic signed [BITWIDTH-1:0] NEG_ONE = -ONE;
    localparam logic signed [BITWIDTH-1:0] HALF    = BITWIDTH'(2**(QM-1));
    localparam logic signed [BITWIDTH-1:0] ZERO    = '0;
    localparam logic [IDX_BITWIDTH-1:0]    LAST_ROW = IDX_BITWIDTH'(NROW - 1);

    state_t                    state;
    logic                      prevReady;
    logic                      capture;
    logic                      load;
    logic                      lastAccept;
    logic                      allLoaded;
    logic [IDX_BITWIDTH-1:0]   rowCnt;
    logic [BITWIDTH-1:0]       rowVal  [NROW];
    logic [BITWIDTH-1:0]       rowBias [NROW];
    logic signed [BITWIDTH:0]  sumWide;
    logic signed [BITWIDTH-1:0] sumSat;
    logic signed [BITWIDTH-1:0] actVal;
`ifndef ACT_TANH_EN
    logic signed [BITWIDTH-1:0] shifted;
`endif

    always_comb begin
        capture    = dataReady & ~prevReady;
        load       = (state == RUN) && !allLoaded && (!outValid || outReady);
        lastAccept = outValid & outReady & outLast;
        busy       = (state == RUN);
        stateDbg   = state;
    end

    // One extra bit of headroom makes the overflow test a simple top-two-bits compare.
    always_comb begin
        sumWide = $signed({rowVal[rowCnt][BITWIDTH-1], rowVal[rowCnt]})
                + $signed({rowBias[rowCnt][BITWIDTH-1], rowBias[rowCnt]});
        if (sumWide[BITWIDTH] != sumWide[BITWIDTH-1])
            sumSat = sumWide[BITWIDTH] ? MINV : MAXV;
        else
            sumSat = sumWide[BITWIDTH-1:0];
    end

`ifdef ACT_TANH_EN
    always_comb begin
        if (sumSat > ONE)
            actVal = ONE;
        else if (sumSat < NEG_ONE)
            actVal = NEG_ONE;
        else
            actVal = sumSat;
    end
`else
    always_comb begin
        shifted = (sumSat >>> 2) + HALF;
        if (shifted < ZERO)
            actVal = ZERO;
        else if (shifted > ONE)
            actVal = ONE;
        else
            actVal = shifted;
    end
`endif

    // The bank is only meaningful in RUN, so it needs no reset value.
    always_ff @(posedge clock) begin
        if (reset && state == IDLE && capture) begin
            for (int r = 0; r < NROW; r++) begin
                rowVal[r]  <= outputVec[r*BITWIDTH +: BITWIDTH];
                rowBias[r] <= biasVec[r*BITWIDTH +: BITWIDTH];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            prevReady <= 1'b0;
            rowCnt    <= '0;
            allLoaded <= 1'b0;
            outValid  <= 1'b0;
            outData   <= '0;
            outIndex  <= '0;
            outLast   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            prevReady <= dataReady;
            case (state)
                IDLE: begin
                    if (capture) begin
                        state     <= RUN;
                        rowCnt    <= '0;
                        allLoaded <= 1'b0;
                    end
                end
                RUN: begin
                    if (capture)
                        overrun <= 1'b1;
                    if (load) begin
                        outValid <= 1'b1;
                        outData  <= actVal;
                        outIndex <= rowCnt;
                        outLast  <= (rowCnt == LAST_ROW);
                        rowCnt   <= rowCnt + 1'b1;
                        if (rowCnt == LAST_ROW)
                            allLoaded <= 1'b1;
                    end else if (outValid && outReady) begin
                        outValid <= 1'b0;
                    end
                    if (lastAccept)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
